// File: rtl/power_manager_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : power_manager_pkg
//  Description : Shared types for the power manager controller: state and
//                fault-cause encodings, default timing values, and the
//                registered output bundle written on every state entry.
//  Revision    : 1.0  initial release
// ============================================================================
package power_manager_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_GAP   = 3'd1,
        ST_UP    = 3'd2,
        ST_ON    = 3'd3,
        ST_DOWN  = 3'd4,
        ST_CYCLE = 3'd5,
        ST_FAULT = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_CRASH  = 2'b01,
        CAUSE_UP_TMO = 2'b10,
        CAUSE_DN_TMO = 2'b11
    } cause_t;

    localparam int unsigned c_gap_cycles_dflt  = 2;
    localparam logic [31:0] c_cycle_delay_dflt = 32'd50_000_000;
    localparam logic [31:0] c_seq_timeout_dflt = 32'd10_000_000;

    // Everything that is a pure function of the state, registered together
    typedef struct packed {
        state_t state;
        logic   power_up;
        logic   power_down;
        logic   busy;
    } ctl_t;

    // Output levels that hold for the whole time a state is occupied
    function automatic ctl_t enter_state(input state_t s);
        ctl_t ctl;
        ctl.state      = s;
        ctl.power_up   = (s == ST_UP) || (s == ST_ON);
        ctl.power_down = (s == ST_DOWN) || (s == ST_OFF) ||
                         (s == ST_CYCLE) || (s == ST_FAULT);
        ctl.busy       = (s == ST_GAP) || (s == ST_UP) ||
                         (s == ST_DOWN) || (s == ST_CYCLE);
        return ctl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/power_manager_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : power_manager_ctrl_if
//  Description : Request/status and sequencer-side signals of the power
//                manager controller. The controller uses the slave modport,
//                the register/sequencer side uses the master modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface power_manager_ctrl_if;

    logic       req_up;
    logic       req_down;
    logic       req_cycle;
    logic       crash;
    logic       fault_clear;
    logic       sequence_complete;
    logic       power_up;
    logic       power_down;
    logic [2:0] power_state;
    logic       busy;
    logic       fault_latched;
    logic [1:0] fault_cause;

    modport master (
        output req_up, req_down, req_cycle, crash, fault_clear, sequence_complete,
        input  power_up, power_down, power_state, busy, fault_latched, fault_cause
    );

    modport slave (
        input  req_up, req_down, req_cycle, crash, fault_clear, sequence_complete,
        output power_up, power_down, power_state, busy, fault_latched, fault_cause
    );

endinterface
`default_nettype wire

// File: rtl/pm_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pm_timer
//  Description : Saturating up-counter with clear, enable and an equality
//                compare. Clear makes the value seen in the current cycle
//                zero, so a clear issued on the cycle a state is entered lets
//                the compare already see 0 in that cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module pm_timer #(
    parameter int WIDTH = 32
) (
    input  wire              clk,
    input  wire              reset_n,
    input  wire              clear,
    input  wire              enable,
    input  wire  [WIDTH-1:0] limit,
    output logic             hit
);

    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_base;

    assign w_base = clear ? '0 : r_count;
    assign hit    = (w_base == limit);

    // Count up from the (possibly cleared) value and stick at all-ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (enable && (w_base != '1)) begin
            r_count <= w_base + c_one;
        end else begin
            r_count <= w_base;
        end
    end

endmodule
`default_nettype wire

// File: rtl/power_manager_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : power_manager_ctrl
//  Description : Arbitrates power requests, owns the power_up/power_down
//                levels of the sequencer, enforces the both-low gap between
//                opposite requests, runs timed power-cycles, times out a
//                stuck sequencer and latches faults.
//  Option      : POWER_AUTO_ON_EN - power on by itself once the post-reset
//                power-down has completed.
//  Revision    : 1.0  initial release
// ============================================================================
module power_manager_ctrl
    import power_manager_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = c_gap_cycles_dflt,
    parameter logic [31:0] CYCLE_DELAY = c_cycle_delay_dflt,
    parameter logic [31:0] SEQ_TIMEOUT = c_seq_timeout_dflt
) (
    input  wire                   clk,
    input  wire                   reset_n,
    power_manager_ctrl_if.slave   bus
);

    // Timer compare values: state left on the cycle the timer equals them
    localparam logic [31:0] c_gap_lim = (GAP_CYCLES > 1) ? 32'(GAP_CYCLES - 1) : 32'd0;
    localparam logic [31:0] c_cyc_lim = (CYCLE_DELAY > 32'd1) ? (CYCLE_DELAY - 32'd1) : 32'd0;

`ifdef POWER_AUTO_ON_EN
    localparam logic c_auto_on = 1'b1;
`else
    localparam logic c_auto_on = 1'b0;
`endif

    ctl_t        r_ctl;
    state_t      r_target;
    cause_t      r_cause;
    logic        r_fault;
    logic        r_cycle_pend;
    logic        r_down_pend;
    logic        r_boot;
    logic        r_tmr_clr;
    logic        w_tmr_en;
    logic [31:0] w_tmr_lim;
    logic        w_tmr_hit;

    // Timer limit and enable follow the current state
    always_comb begin
        w_tmr_en  = 1'b0;
        w_tmr_lim = '1;
        case (r_ctl.state)
            ST_GAP:   begin w_tmr_en = 1'b1; w_tmr_lim = c_gap_lim;   end
            ST_UP:    begin w_tmr_en = 1'b1; w_tmr_lim = SEQ_TIMEOUT; end
            ST_DOWN:  begin w_tmr_en = 1'b1; w_tmr_lim = SEQ_TIMEOUT; end
            ST_CYCLE: begin w_tmr_en = 1'b1; w_tmr_lim = c_cyc_lim;   end
            default:  begin w_tmr_en = 1'b0; w_tmr_lim = '1;          end
        endcase
    end

    pm_timer #(
        .WIDTH   (32)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (r_tmr_clr),
        .enable  (w_tmr_en),
        .limit   (w_tmr_lim),
        .hit     (w_tmr_hit)
    );

    // Controller FSM; every state change also re-arms the timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctl        <= enter_state(ST_GAP);
            r_target     <= ST_DOWN;
            r_cause      <= CAUSE_NONE;
            r_fault      <= 1'b0;
            r_cycle_pend <= 1'b0;
            r_down_pend  <= 1'b0;
            r_boot       <= 1'b1;
            r_tmr_clr    <= 1'b1;
        end else begin
            r_tmr_clr <= 1'b0;
            if (bus.crash && (r_ctl.state != ST_DOWN) && (r_ctl.state != ST_FAULT)) begin
                r_fault      <= 1'b1;
                r_cycle_pend <= 1'b0;
                r_down_pend  <= 1'b0;
                r_boot       <= 1'b0;
                if ((r_ctl.state == ST_GAP) && (r_target == ST_DOWN)) begin
                    // Already heading down: keep the gap running and keep
                    // an earlier cause rather than restarting on a held crash
                    if (r_cause == CAUSE_NONE) begin
                        r_cause <= CAUSE_CRASH;
                    end
                end else begin
                    r_cause   <= CAUSE_CRASH;
                    r_target  <= ST_DOWN;
                    r_ctl     <= enter_state(ST_GAP);
                    r_tmr_clr <= 1'b1;
                end
            end else begin
                case (r_ctl.state)
                    ST_GAP: begin
                        if (bus.req_down && (r_target == ST_UP)) begin
                            r_down_pend <= 1'b1;
                        end
                        if (w_tmr_hit) begin
                            r_ctl     <= enter_state(r_target);
                            r_tmr_clr <= 1'b1;
                        end
                    end
                    ST_UP: begin
                        if (bus.req_down) begin
                            r_down_pend <= 1'b1;
                        end
                        if (bus.sequence_complete) begin
                            r_ctl     <= enter_state(ST_ON);
                            r_tmr_clr <= 1'b1;
                        end else if (w_tmr_hit) begin
                            r_fault      <= 1'b1;
                            r_cause      <= CAUSE_UP_TMO;
                            r_cycle_pend <= 1'b0;
                            r_down_pend  <= 1'b0;
                            r_boot       <= 1'b0;
                            r_target     <= ST_DOWN;
                            r_ctl        <= enter_state(ST_GAP);
                            r_tmr_clr    <= 1'b1;
                        end
                    end
                    ST_ON: begin
                        if (bus.req_down || r_down_pend) begin
                            r_down_pend <= 1'b0;
                            r_target    <= ST_DOWN;
                            r_ctl       <= enter_state(ST_GAP);
                            r_tmr_clr   <= 1'b1;
                        end else if (bus.req_cycle) begin
                            r_cycle_pend <= 1'b1;
                            r_target     <= ST_DOWN;
                            r_ctl        <= enter_state(ST_GAP);
                            r_tmr_clr    <= 1'b1;
                        end
                    end
                    ST_DOWN: begin
                        // A crash here only marks the fault; completion
                        // then lands in FAULT instead of OFF or CYCLE
                        if (bus.crash) begin
                            r_fault      <= 1'b1;
                            r_cycle_pend <= 1'b0;
                            if (r_cause == CAUSE_NONE) begin
                                r_cause <= CAUSE_CRASH;
                            end
                        end
                        if (bus.sequence_complete) begin
                            r_boot    <= 1'b0;
                            r_tmr_clr <= 1'b1;
                            if (r_fault || bus.crash) begin
                                r_cycle_pend <= 1'b0;
                                r_ctl        <= enter_state(ST_FAULT);
                            end else if (r_cycle_pend) begin
                                r_ctl <= enter_state(ST_CYCLE);
                            end else if (c_auto_on && r_boot) begin
                                r_target <= ST_UP;
                                r_ctl    <= enter_state(ST_GAP);
                            end else begin
                                r_ctl <= enter_state(ST_OFF);
                            end
                        end else if (w_tmr_hit) begin
                            r_fault      <= 1'b1;
                            r_cause      <= CAUSE_DN_TMO;
                            r_cycle_pend <= 1'b0;
                            r_boot       <= 1'b0;
                            r_ctl        <= enter_state(ST_FAULT);
                            r_tmr_clr    <= 1'b1;
                        end
                    end
                    ST_OFF: begin
                        // req_down outranks the power-on requests and is a
                        // no-op here, so it swallows a coincident req_up
                        if (!bus.req_down && (bus.req_cycle || bus.req_up)) begin
                            r_target  <= ST_UP;
                            r_ctl     <= enter_state(ST_GAP);
                            r_tmr_clr <= 1'b1;
                        end
                    end
                    ST_CYCLE: begin
                        if (w_tmr_hit) begin
                            r_cycle_pend <= 1'b0;
                            r_target     <= ST_UP;
                            r_ctl        <= enter_state(ST_GAP);
                            r_tmr_clr    <= 1'b1;
                        end
                    end
                    ST_FAULT: begin
                        if (bus.fault_clear && !bus.crash) begin
                            r_fault   <= 1'b0;
                            r_cause   <= CAUSE_NONE;
                            r_ctl     <= enter_state(ST_OFF);
                            r_tmr_clr <= 1'b1;
                        end
                    end
                    default: begin
                        r_target  <= ST_DOWN;
                        r_ctl     <= enter_state(ST_GAP);
                        r_tmr_clr <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.power_up      = r_ctl.power_up;
    assign bus.power_down    = r_ctl.power_down;
    assign bus.power_state   = r_ctl.state;
    assign bus.busy          = r_ctl.busy;
    assign bus.fault_latched = r_fault;
    assign bus.fault_cause   = r_cause;

endmodule
`default_nettype wire

// File: doc/power_manager_ctrl.md
# power_manager_ctrl

Controller that owns the `power_up`/`power_down` level inputs of `power_sequence` and arbitrates board power requests from the software register file, the front-panel button and the voltage/temperature monitor crash line. It guarantees the mandatory both-low gap between opposite requests, runs timed power-cycles, detects a sequencer that never completes, and latches faults. It sits in the power manager between the register/bus logic and `power_sequence`.

## Interface
- `GAP_CYCLES`, 2: both-low cycles before any new request level; minimum 1.
- `CYCLE_DELAY`, 32'd50_000_000: OFF dwell inside a power-cycle, in `clk` cycles.
- `SEQ_TIMEOUT`, 32'd10_000_000: maximum cycles to wait for `sequence_complete`.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_up`  in  1  single-cycle pulse: power on.
- `req_down`  in  1  single-cycle pulse: power off.
- `req_cycle`  in  1  single-cycle pulse: power off, wait `CYCLE_DELAY`, power on.
- `crash`  in  1  level from the monitor; high = fault.
- `fault_clear`  in  1  single-cycle pulse: clear the latched fault.
- `sequence_complete`  in  1  from `power_sequence`.
- `power_up`  out  1  level to `power_sequence`.
- `power_down`  out  1  level to `power_sequence`.
- `power_state`  out  3  OFF=0, GAP=1, UP=2, ON=3, DOWN=4, CYCLE=5, FAULT=6.
- `busy`  out  1  high in GAP, UP, DOWN and CYCLE.
- `fault_latched`  out  1  sticky fault flag.
- `fault_cause`  out  2  00 none, 01 crash, 10 up-timeout, 11 down-timeout.

## Operation
- All outputs are registered. Reset values:
  - `power_up`=0, `power_down`=0, `fault_latched`=0, `fault_cause`=00, `busy`=1.
  - State GAP with target DOWN, so the board is forced off after reset.
- GAP: both outputs low for `GAP_CYCLES`, then enter the target state (UP or DOWN). `power_sequence` resets only on both-low, so every UP↔DOWN change passes through GAP.
- UP: `power_up`=1; timer runs from 0.
  - `sequence_complete` → ON.
  - Timer reaches `SEQ_TIMEOUT` → fault, cause 10.
- ON: `power_up` held at 1.
  - `req_down` → GAP(target DOWN).
  - `req_cycle` → GAP(target DOWN) and sets `cycle_pend`.
- DOWN: `power_down`=1.
  - `sequence_complete` → FAULT if `fault_latched`, else CYCLE if `cycle_pend`, else OFF.
  - Timeout → cause 11, `fault_latched` set, then FAULT.
- OFF: `power_down` held at 1. `req_up` or `req_cycle` → GAP(target UP).
- CYCLE: `power_down` held at 1 for `CYCLE_DELAY` cycles, then clear `cycle_pend` → GAP(target UP).
- FAULT: `power_down` held at 1. `req_up` and `req_cycle` are ignored. `fault_clear` → clear flag and cause → OFF.
- Fault entry: `crash` high in any state except DOWN and FAULT sets `fault_latched`, cause 01, clears `cycle_pend`, then → GAP(target DOWN). In DOWN, crash only sets the flag, and DOWN completes into FAULT.
- Priority within one cycle: crash > `fault_clear` > `req_down` > `req_cycle` > `req_up`.
- `req_down` in UP or GAP(target UP): latched as `down_pend`, served on reaching ON (→ GAP target DOWN the next cycle).
- Other requests during busy states are dropped.
- `fault_clear` while `crash` is still high: ignored.
- Timer is 32-bit, cleared on every state entry, saturating; no wrap.

## Timing
- Request pulse at edge N in OFF: `power_state`=GAP at N+1; `power_up` rises at N+1+`GAP_CYCLES`.
- `sequence_complete` sampled at edge M in UP: `power_state`=ON at M+1; `busy` falls at M+1.
- Timeout: fault taken on the edge where the timer equals `SEQ_TIMEOUT` (`SEQ_TIMEOUT`+1 cycles after UP entry).
- `power_up` and `power_down` are never high in the same cycle.
- `reset_n` asserted mid-sequence: both outputs drop asynchronously. After release, the block runs GAP and then DOWN.

## Configuration
- `POWER_AUTO_ON_EN` defined: once the post-reset DOWN completes, the block behaves as if `req_up` arrived, so the board powers on unattended (not after a fault).
- Not defined: the block rests in OFF until a request arrives.

## Structure
- Shared package `power_manager_pkg`: state encodings, `fault_cause` codes, default `GAP_CYCLES`/`CYCLE_DELAY`/`SEQ_TIMEOUT`.
- One sub-module, `pm_timer`: 32-bit clear/enable/saturating counter with a compare output. Used for the gap, timeout and cycle delay.

## Test plan
- Reset, sequencer model completes 5 cycles after `power_down` → OFF, `power_down`=1, `busy`=0. With `POWER_AUTO_ON_EN` → ends in ON.
- `req_up` at edge N → `power_up` rises at N+3 (`GAP_CYCLES`=2); complete after 10 cycles → ON. Then `req_down` → both outputs low for 2 cycles, then `power_down`=1.
- `req_cycle` in ON (`CYCLE_DELAY`=100) → DOWN, CYCLE for 100 cycles, GAP, UP, ON; no cycle with both outputs high.
- `sequence_complete` never asserted (`SEQ_TIMEOUT`=20) → `fault_cause`=10, DOWN, FAULT. `req_up` ignored. `fault_clear` → OFF, `fault_cause`=00.
- `crash` pulse during UP → GAP, DOWN, FAULT, cause 01. `fault_clear` with `crash` still high → stays FAULT.
- `req_down` at the same edge as `req_up` in OFF → no action. `req_down` during UP → ON for one cycle, then GAP(target DOWN).
